// File: rtl/midi_note_ctrl.sv
// Monophonic MIDI note front-end: parses a MIDI byte stream (running status, SysEx,
// real-time) and emits registered note-on / note-off events for the envelope manager.
module midi_note_ctrl #(
  parameter bit OMNI = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic [3:0] channel,
  output logic       new_note_pulse,
  output logic       release_note_pulse,
  output logic [6:0] note_number,
  output logic [6:0] velocity,
  output logic       note_active
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_D1 = 2'd1;
  localparam logic [1:0] WAIT_D2 = 2'd2;
  localparam logic [1:0] SYSEX   = 2'd3;

  logic [1:0] state;
  logic [7:0] run_status;
  logic [6:0] d1;

  logic is_realtime;
  logic is_data;
  logic msg_done_p0;
  logic chan_ok_p0;
  logic note_on_p0;
  logic note_off_p0;
  logic release_hit_p0;

  // Stage p0: decode the incoming byte and the message it completes
  always_comb begin
    is_realtime    = byte_data >= 8'hF8;
    is_data        = ~byte_data[7];
    msg_done_p0    = byte_valid && is_data && (state == WAIT_D2);
    chan_ok_p0     = OMNI || (run_status[3:0] == channel);
    note_on_p0     = msg_done_p0 && chan_ok_p0 && (run_status[7:4] == 4'h9) &&
                     (byte_data[6:0] != 7'd0);
    note_off_p0    = msg_done_p0 && chan_ok_p0 &&
                     ((run_status[7:4] == 4'h8) ||
                      ((run_status[7:4] == 4'h9) && (byte_data[6:0] == 7'd0)));
    release_hit_p0 = note_off_p0 && note_active && (d1 == note_number);
  end

  // Stage p1: registered outputs and parser state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      run_status         <= 8'h00;
      d1                 <= 7'd0;
      new_note_pulse     <= 1'b0;
      release_note_pulse <= 1'b0;
      note_number        <= 7'd0;
      velocity           <= 7'd0;
      note_active        <= 1'b0;
    end else begin
      new_note_pulse     <= note_on_p0;
      release_note_pulse <= release_hit_p0;
      if (note_on_p0) begin
        note_number <= d1;
        velocity    <= byte_data[6:0];
        note_active <= 1'b1;
      end else if (release_hit_p0) begin
        note_active <= 1'b0;
      end

      // Real-time bytes are transparent to the parser, even inside SysEx
      if (byte_valid && !is_realtime) begin
        if (state == SYSEX) begin
          if (byte_data == 8'hF7) state <= IDLE;
        end else if (byte_data == 8'hF0) begin
          state      <= SYSEX;
          run_status <= 8'h00;
        end else if (byte_data >= 8'hF1) begin
          state      <= IDLE;
          run_status <= 8'h00;
        end else if (!is_data) begin
          state      <= WAIT_D1;
          run_status <= byte_data;
        end else if (state == WAIT_D1) begin
          d1 <= byte_data[6:0];
          // Program change and channel pressure carry a single data byte
          if ((run_status[7:4] == 4'hC) || (run_status[7:4] == 4'hD)) state <= WAIT_D1;
          else state <= WAIT_D2;
        end else if (state == WAIT_D2) begin
          state <= WAIT_D1;
        end
      end
    end
  end

endmodule
